// File: rtl/mips_sram_cpu.sv
// Multicycle 32-bit MIPS-subset CPU on a shared 16-bit asynchronous SRAM (IS61LV25616-style pins).
// Each 32-bit word moves as two little-endian halfword cycles, one clock per halfword.
module mips_sram_cpu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic [17:0] addr,
    inout  wire  [15:0] data,
    output logic        wre,
    output logic        oute,
    output logic        hb_mask,
    output logic        lb_mask,
    output logic        chip_en
);

    typedef enum logic [2:0] {
        S_FETCH_LO = 3'd0,
        S_FETCH_HI = 3'd1,
        S_DECODE   = 3'd2,
        S_EXEC     = 3'd3,
        S_MEM_LO   = 3'd4,
        S_MEM_HI   = 3'd5,
        S_WB       = 3'd6
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    state_t      state_q, state_d;
    logic [31:0] pc_q, ir_q, a_q, b_q, alu_q, mdr_q;
    logic [31:0] rf_q [32];

    logic [5:0]  op_s, funct_s;
    logic [4:0]  rs_s, rt_s, dest_s;
    logic [31:0] imm_s, alu_s;
    logic        funct_ok_s, mem_rd_s, mem_wr_s;
    logic [17:0] addr_s;
    logic [15:0] wdata_s;

    assign op_s    = ir_q[31:26];
    assign rs_s    = ir_q[25:21];
    assign rt_s    = ir_q[20:16];
    assign funct_s = ir_q[5:0];
    assign imm_s   = {{16{ir_q[15]}}, ir_q[15:0]};
    assign dest_s  = (op_s == OP_RTYPE) ? ir_q[15:11] : rt_s;

    // Reset gates every strobe combinationally so an abort never lets a pending write through.
    assign chip_en = ~((mem_rd_s | mem_wr_s) & reset);
    assign oute    = ~(mem_rd_s & reset);
    assign wre     = ~(mem_wr_s & reset);
    assign hb_mask = chip_en;
    assign lb_mask = chip_en;
    assign addr    = reset ? addr_s : 18'd0;
    assign data    = (mem_wr_s & reset) ? wdata_s : 16'hzzzz;

    // ALU: R-type functions, otherwise base + sign-extended immediate.
    always_comb begin
        alu_s      = 32'd0;
        funct_ok_s = 1'b0;
        if (op_s == OP_RTYPE) begin
            funct_ok_s = 1'b1;
            case (funct_s)
                FN_ADD:  alu_s = a_q + b_q;
                FN_SUB:  alu_s = a_q - b_q;
                FN_AND:  alu_s = a_q & b_q;
                FN_OR:   alu_s = a_q | b_q;
                FN_SLT:  alu_s = {31'd0, ($signed(a_q) < $signed(b_q))};
                default: funct_ok_s = 1'b0;
            endcase
        end else begin
            alu_s = a_q + imm_s;
        end
    end

    // Next-state and SRAM cycle control.
    always_comb begin
        state_d  = state_q;
        mem_rd_s = 1'b0;
        mem_wr_s = 1'b0;
        addr_s   = 18'd0;
        wdata_s  = 16'd0;
        case (state_q)
            S_FETCH_LO: begin
                mem_rd_s = 1'b1;
                addr_s   = pc_q[18:1];
                state_d  = S_FETCH_HI;
            end
            S_FETCH_HI: begin
                mem_rd_s = 1'b1;
                addr_s   = pc_q[18:1] + 18'd1;
                state_d  = S_DECODE;
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                case (op_s)
                    OP_RTYPE:     state_d = funct_ok_s ? S_WB : S_FETCH_LO;
                    OP_ADDI:      state_d = S_WB;
                    OP_LW, OP_SW: state_d = S_MEM_LO;
                    default:      state_d = S_FETCH_LO;
                endcase
            end
            S_MEM_LO: begin
                addr_s   = alu_q[18:1];
                mem_wr_s = (op_s == OP_SW);
                mem_rd_s = (op_s != OP_SW);
                wdata_s  = b_q[15:0];
                state_d  = S_MEM_HI;
            end
            S_MEM_HI: begin
                addr_s   = alu_q[18:1] + 18'd1;
                mem_wr_s = (op_s == OP_SW);
                mem_rd_s = (op_s != OP_SW);
                wdata_s  = b_q[31:16];
                state_d  = (op_s == OP_LW) ? S_WB : S_FETCH_LO;
            end
            S_WB:    state_d = S_FETCH_LO;
            default: state_d = S_FETCH_LO;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH_LO;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: instruction, operands, ALU result, memory data, PC.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q  <= RESET_PC;
            ir_q  <= 32'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            alu_q <= 32'd0;
            mdr_q <= 32'd0;
        end else begin
            case (state_q)
                S_FETCH_LO: ir_q[15:0]  <= data;
                S_FETCH_HI: ir_q[31:16] <= data;
                S_DECODE: begin
                    pc_q <= pc_q + 32'd4;
                    a_q  <= rf_q[rs_s];
                    b_q  <= rf_q[rt_s];
                end
                S_EXEC: begin
                    alu_q <= alu_s;
                    if ((op_s == OP_BEQ) && (a_q == b_q)) begin
                        pc_q <= pc_q + (imm_s << 2);
                    end else if (op_s == OP_J) begin
                        pc_q <= {pc_q[31:28], ir_q[25:0], 2'b00};
                    end else begin
                        pc_q <= pc_q;
                    end
                end
                S_MEM_LO: mdr_q[15:0]  <= data;
                S_MEM_HI: mdr_q[31:16] <= data;
                default: ;
            endcase
        end
    end

    // Register file; $0 is never written so it always reads zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= 32'd0;
            end
        end else if ((state_q == S_WB) && (dest_s != 5'd0)) begin
            rf_q[dest_s] <= (op_s == OP_LW) ? mdr_q : alu_q;
        end
    end

endmodule

// File: tb/tb_mips_sram_cpu.sv
// Directed bench for mips_sram_cpu with an inline behavioural 16-bit SRAM holding a small program.
module tb_mips_sram_cpu;

    logic        clock;
    logic        reset;
    logic [17:0] addr;
    wire  [15:0] data;
    logic        wre, oute, hb_mask, lb_mask, chip_en;

    logic [15:0] mem [0:255];
    int          wr_count;
    int          checks;
    int          failures;
    int          wc;

    mips_sram_cpu #(.RESET_PC(32'h0000_0000)) dut (
        .clock   (clock),
        .reset   (reset),
        .addr    (addr),
        .data    (data),
        .wre     (wre),
        .oute    (oute),
        .hb_mask (hb_mask),
        .lb_mask (lb_mask),
        .chip_en (chip_en)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [15:0] rom(input int i);
        case (i)
            8'h00: rom = 16'h0005;  8'h01: rom = 16'h2001; // addi $1,$0,5
            8'h02: rom = 16'h0100;  8'h03: rom = 16'hAC01; // sw   $1,0x100($0)
            8'h04: rom = 16'h0100;  8'h05: rom = 16'h8C02; // lw   $2,0x100($0)
            8'h06: rom = 16'h1820;  8'h07: rom = 16'h0022; // add  $3,$1,$2
            8'h08: rom = 16'h2022;  8'h09: rom = 16'h0001; // sub  $4,$0,$1
            8'h0A: rom = 16'h282A;  8'h0B: rom = 16'h0081; // slt  $5,$4,$1
            8'h0C: rom = 16'h3024;  8'h0D: rom = 16'h0064; // and  $6,$3,$4
            8'h0E: rom = 16'h3825;  8'h0F: rom = 16'h0026; // or   $7,$1,$6
            8'h10: rom = 16'h0007;  8'h11: rom = 16'h2000; // addi $0,$0,7
            8'h12: rom = 16'h0000;  8'h13: rom = 16'hFC00; // unknown opcode
            8'h14: rom = 16'h000C;  8'h15: rom = 16'h0800; // j    48
            8'h16: rom = 16'h0001;  8'h17: rom = 16'h2008; // addi $8,$0,1 (skipped)
            8'h18: rom = 16'h0005;  8'h19: rom = 16'h1027; // beq  $1,$7,+5 (not taken)
            8'h1A: rom = 16'hFFFF;  8'h1B: rom = 16'h1000; // beq  $0,$0,-1
            default: rom = 16'h0000;
        endcase
    endfunction

    // SRAM: asynchronous read, write latched at the clock edge; reloads the image while reset is low.
    assign data = (!chip_en && !oute && wre) ? mem[addr[7:0]] : 16'hzzzz;
    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= rom(i);
        end
        if (!chip_en && !wre) begin
            mem[addr[7:0]] <= data;
            wr_count <= wr_count + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_eq(tag, {addr, wre, oute, chip_en, hb_mask, lb_mask}, {18'd0, 5'b11111});
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        #1;
        check_idle("reset_now");
        step(2);
        check_idle("reset_held");

        @(negedge clock);
        reset = 1'b1;
        #1;
        check_eq("fetch_lo", {addr, wre, oute, chip_en, hb_mask, lb_mask}, {18'd0, 5'b10000});
        step(1);
        check_eq("fetch_hi", {addr, oute, chip_en}, {18'd1, 2'b00});
        step(1);
        check_eq("decode_idle", {wre, oute, chip_en}, 3'b111);
        step(3);
        check_eq("addi_r1", dut.rf_q[1], 32'd5);
        check_eq("addi_next", addr, 18'd2);

        step(4);
        check_eq("sw_lo", {addr, wre, oute, chip_en, data}, {18'h80, 3'b010, 16'h0005});
        step(1);
        check_eq("sw_hi", {addr, wre, oute, chip_en, data}, {18'h81, 3'b010, 16'h0000});
        step(1);
        check_eq("sw_next", addr, 18'd4);
        check_eq("sw_mem", {mem[8'h80], mem[8'h81]}, 32'h0005_0000);

        step(4);
        check_eq("lw_lo", {addr, wre, oute, chip_en}, {18'h80, 3'b100});
        step(1);
        check_eq("lw_hi", {addr, wre, oute, chip_en}, {18'h81, 3'b100});
        step(2);
        check_eq("lw_next", addr, 18'd6);
        check_eq("lw_r2", dut.rf_q[2], 32'd5);

        step(30);
        check_eq("rtype_next", addr, 18'h12);
        check_eq("add_r3", dut.rf_q[3], 32'd10);
        check_eq("sub_r4", dut.rf_q[4], 32'hFFFF_FFFB);
        check_eq("slt_r5", dut.rf_q[5], 32'd1);
        check_eq("and_r6", dut.rf_q[6], 32'h0000_000A);
        check_eq("or_r7", dut.rf_q[7], 32'h0000_000F);
        check_eq("r0_zero", dut.rf_q[0], 32'd0);

        step(4);
        check_eq("unknown_next", addr, 18'h14);
        step(4);
        check_eq("j_target", addr, 18'h18);
        check_eq("j_skip_r8", dut.rf_q[8], 32'd0);
        step(4);
        check_eq("beq_not_taken", addr, 18'h1A);
        step(1);
        check_eq("beq_loop_hi", addr, 18'h1B);
        step(3);
        check_eq("beq_loop_1", addr, 18'h1A);
        step(4);
        check_eq("beq_loop_2", addr, 18'h1A);

        @(negedge clock);
        reset = 1'b0;
        #1;
        check_idle("reset_async");
        check_eq("reset_rf", dut.rf_q[7], 32'd0);
        step(2);
        @(negedge clock);
        reset = 1'b1;
        step(5);
        check_eq("rerun_addi", addr, 18'd2);
        step(4);
        check_eq("rerun_sw_lo", {addr, wre}, {18'h80, 1'b0});
        wc = wr_count;
        #1;
        reset = 1'b0;
        #1;
        check_idle("abort_strobes");
        step(1);
        check_eq("abort_no_write", wr_count, wc);
        check_eq("abort_mem", {16'd0, mem[8'h80]}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_eq("restart_fetch", {addr, oute, chip_en}, {18'd0, 2'b00});
        step(1);
        check_eq("restart_hi", addr, 18'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
